// File: rtl/snd_dac_out.sv
// snd_dac_out: per-channel 1-bit audio DAC stream generator.
// Converts signed samples to offset-binary duties, double-buffers them
// (shadow -> active at frame wrap) and modulates each channel with either
// PWM (MODE 0) or a first-order sigma-delta accumulator (MODE 1).
module snd_dac_out #(
  parameter int CH   = 2,
  parameter int DW   = 16,
  parameter int PW   = 8,
  parameter int MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic [CH*DW-1:0] sample_in,
  input  logic             sample_valid,
  output logic [CH-1:0]    dac_out,
  output logic             frame_start,
  output logic             overrun
);

  logic [PW-1:0]          cnt_q, cnt_d;
  logic [CH-1:0][PW-1:0]  shadow_q, active_q;
  logic [CH-1:0][PW-1:0]  duty_in, duty_use;
  logic [CH-1:0][PW:0]    acc_q, acc_d;
  logic [CH-1:0]          dac_q, dac_d;
  logic                   pending_q, overrun_q, frame_start_q;
  logic                   wrap;

  // Wrap tick: last counter value of the frame on an enabled tick.
  assign wrap = cen && (cnt_q == {PW{1'b1}});

  // Duty conversion, duty selection at the wrap, and modulator next state.
  always_comb begin
    // NOTE: every variable gets a default before any conditional logic so
    // no path leaves it unassigned and no latch is inferred.
    cnt_d    = cnt_q + 1'b1;
    duty_in  = '0;
    duty_use = '0;
    acc_d    = '0;
    dac_d    = '0;
    for (int k = 0; k < CH; k++) begin
      // Top PW bits with the sign bit inverted give offset binary.
      duty_in[k]  = {~sample_in[k*DW + DW-1], sample_in[k*DW + DW-2 -: PW-1]};
      // On the wrap the new duty drives the very first tick of the frame,
      // which gives one clk of latency from wrap to modulated output.
      duty_use[k] = (wrap && pending_q) ? shadow_q[k] : active_q[k];
      acc_d[k]    = {1'b0, acc_q[k][PW-1:0]} + {1'b0, duty_use[k]};
      if (MODE == 0) begin
        dac_d[k] = (cnt_d < duty_use[k]);
      end else begin
        dac_d[k] = acc_d[k][PW];
      end
    end
  end

  // Sample capture, frame sequencing and modulator state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: shadow/active duties are a handful of flops, not a memory
    // array, so clearing them in the asynchronous reset costs nothing.
    if (!rst_n) begin
      cnt_q         <= '0;
      shadow_q      <= '0;
      active_q      <= '0;
      acc_q         <= '0;
      dac_q         <= '0;
      pending_q     <= 1'b0;
      overrun_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values; the wrap reads the old shadow while a same-cycle
      // sample lands in the new one.
      frame_start_q <= wrap;
      // A pending sample consumed by a simultaneous wrap is not lost.
      overrun_q     <= sample_valid && pending_q && !wrap;
      if (sample_valid) begin
        shadow_q <= duty_in;
      end
      if (sample_valid) begin
        pending_q <= 1'b1;
      end else if (wrap) begin
        pending_q <= 1'b0;
      end
      if (wrap && pending_q) begin
        active_q <= shadow_q;
      end
      if (cen) begin
        cnt_q <= cnt_d;
        acc_q <= acc_d;
        dac_q <= dac_d;
      end
    end
  end

  assign dac_out     = dac_q;
  assign frame_start = frame_start_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_snd_dac_out.sv
// Directed bench for snd_dac_out: runs a PWM and a sigma-delta instance
// side by side on the same stimulus and checks per-frame behaviour.
module tb_snd_dac_out;

  localparam int CH = 2;
  localparam int DW = 16;
  localparam int PW = 8;
  localparam int FR = 256;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cen = 1'b0;
  logic             sample_valid = 1'b0;
  logic [CH*DW-1:0] sample_in = '0;
  logic [CH-1:0]    dac_p, dac_s;
  logic             fs_p, fs_s, ov_p, ov_s;

  int checks = 0;
  int errors = 0;
  int clk_cnt = 0;
  int fs_cnt = 0;
  int hold_bad = 0;
  int maxrun_s1 = 0;

  snd_dac_out #(.CH(CH), .DW(DW), .PW(PW), .MODE(0)) u_pwm (
    .clk(clk), .rst_n(rst_n), .cen(cen), .sample_in(sample_in),
    .sample_valid(sample_valid), .dac_out(dac_p), .frame_start(fs_p),
    .overrun(ov_p)
  );

  snd_dac_out #(.CH(CH), .DW(DW), .PW(PW), .MODE(1)) u_sd (
    .clk(clk), .rst_n(rst_n), .cen(cen), .sample_in(sample_in),
    .sample_valid(sample_valid), .dac_out(dac_s), .frame_start(fs_s),
    .overrun(ov_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; outputs are then sampled at the falling edge.
  task automatic tick();
    @(negedge clk);
    clk_cnt++;
    if (fs_p) fs_cnt++;
  endtask

  // One modulator tick: step 1 = cen every clk, step 4 = cen 1-in-4.
  task automatic advance(input int step);
    logic [CH-1:0] hp, hs;
    if (step == 1) begin
      cen = 1'b1;
      tick();
    end else begin
      hp  = dac_p;
      hs  = dac_s;
      cen = 1'b0;
      repeat (3) begin
        tick();
        if (dac_p !== hp || dac_s !== hs) hold_bad++;
      end
      cen = 1'b1;
      tick();
    end
  endtask

  task automatic strobe(input logic [15:0] s0, input logic [15:0] s1);
    sample_in    = {s1, s0};
    sample_valid = 1'b1;
    cen          = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_fs(input int step, input string tag);
    int n;
    n = 0;
    while (fs_p !== 1'b1 && n < 600) begin
      advance(step);
      n++;
    end
    check({tag, "_fs_seen"}, fs_p, 1);
  endtask

  // Observe one frame starting at the frame_start cycle.
  task automatic measure(input int step, input int d0, input int d1, input string tag);
    int on_p0, on_p1, on_s0, on_s1, pat_bad, run, maxrun;
    on_p0 = 0; on_p1 = 0; on_s0 = 0; on_s1 = 0;
    pat_bad = 0; run = 0; maxrun = 0;
    clk_cnt = 0; fs_cnt = 0; hold_bad = 0;
    for (int i = 0; i < FR; i++) begin
      on_p0 += int'(dac_p[0]);
      on_p1 += int'(dac_p[1]);
      on_s0 += int'(dac_s[0]);
      on_s1 += int'(dac_s[1]);
      if (dac_p[0] !== (i < d0)) pat_bad++;
      if (dac_p[1] !== (i < d1)) pat_bad++;
      if (dac_s[1]) run++; else run = 0;
      if (run > maxrun) maxrun = run;
      advance(step);
    end
    maxrun_s1 = maxrun;
    check({tag, "_fs_once"}, fs_cnt, 1);
    check({tag, "_fs_at_end"}, fs_p, 1);
    check({tag, "_frame_clks"}, clk_cnt, FR * step);
    check({tag, "_pwm0_ones"}, on_p0, d0);
    check({tag, "_pwm1_ones"}, on_p1, d1);
    check({tag, "_sd0_ones"}, on_s0, d0);
    check({tag, "_sd1_ones"}, on_s1, d1);
    check({tag, "_pwm_shape"}, pat_bad, 0);
    if (step != 1) check({tag, "_hold_cen0"}, hold_bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [CH-1:0] idle_or;
    int n;

    // Reset state.
    cen = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dac_pwm", dac_p, 0);
    check("rst_dac_sd", dac_s, 0);
    check("rst_fs", fs_p, 0);
    check("rst_ov", ov_p, 0);
    rst_n = 1'b1;

    // Mid-scale and negative full-scale: 128 of 256 high, constant 0.
    strobe(16'h0000, 16'h8000);
    wait_fs(1, "f1");
    measure(1, 128, 0, "half_zero");

    // Positive full-scale (255) and 0xC000 (64).
    strobe(16'h7FFF, 16'hC000);
    wait_fs(1, "f2");
    measure(1, 255, 64, "full_quarter");
    check("sd_max_run", maxrun_s1, 1);

    // Two strobes in one frame: overrun after the second only.
    strobe(16'h4000, 16'h0000);
    check("ov_first_pwm", ov_p, 0);
    repeat (10) advance(1);
    strobe(16'hE000, 16'h2000);
    check("ov_second_pwm", ov_p, 1);
    check("ov_second_sd", ov_s, 1);
    advance(1);
    check("ov_one_clk", ov_p, 0);
    wait_fs(1, "f3");
    measure(1, 96, 160, "second_wins");

    // Strobe on the wrap: prior shadow this frame, new value the next.
    strobe(16'h0000, 16'h0000);
    repeat (254) advance(1);
    check("pre_wrap_no_fs", fs_p, 0);
    strobe(16'hF000, 16'h1000);
    check("wrap_fs", fs_p, 1);
    measure(1, 128, 128, "prior_shadow");
    measure(1, 112, 144, "pending_kept");

    // cen 1-in-4: 1024-clk frames, same per-tick sequence.
    strobe(16'hA000, 16'h6000);
    wait_fs(4, "dec");
    measure(4, 32, 224, "cen_div4");

    // Asynchronous reset mid-frame.
    repeat (3) advance(4);
    check("pre_rst_high", dac_p[0], 1);
    cen = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dac_pwm", dac_p, 0);
    check("async_rst_dac_sd", dac_s, 0);
    check("async_rst_fs", fs_p, 0);
    check("async_rst_ov", ov_p, 0);
    sample_in    = {16'h7FFF, 16'h7FFF};
    sample_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_held_dac", dac_p | dac_s, 0);
    sample_valid = 1'b0;
    @(negedge clk);
    #3 rst_n = 1'b1;
    n = 0;
    idle_or = '0;
    while (fs_p !== 1'b1 && n < 600) begin
      advance(1);
      n++;
      idle_or = idle_or | dac_p | dac_s;
    end
    check("rst_first_fs_ticks", n, 256);
    check("rst_dac_idle", idle_or, 0);
    measure(1, 0, 0, "idle_frame");
    strobe(16'h0000, 16'h0000);
    wait_fs(1, "f4");
    measure(1, 128, 128, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
